// File: rtl/fpu_cvt_unpack_pkg.sv
// Shared FPU definitions: rounding-mode encodings, binary32 field constants
// and the class-flag bundle used by the float-to-int conversion front end.
package fpu_cvt_unpack_pkg;

  localparam logic [2:0] RM_RNE = 3'b000;
  localparam logic [2:0] RM_RTZ = 3'b001;
  localparam logic [2:0] RM_RDN = 3'b010;
  localparam logic [2:0] RM_RUP = 3'b011;
  localparam logic [2:0] RM_RMM = 3'b100;
  localparam logic [2:0] RM_DYN = 3'b111;

  localparam logic [7:0] EXP_BIAS     = 8'd127;
  localparam logic [7:0] EXP_ALL_ONES = 8'hFF;

  typedef struct packed {
    logic is_nan;
    logic is_snan;
    logic is_inf;
    logic is_zero;
    logic is_sub;
  } fp_class_t;

  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] frac;
  } fp32_t;

  // The instruction field selects the mode unless it asks for the dynamic one.
  function automatic logic [2:0] resolve_rm(input logic [2:0] rm, input logic [2:0] frm);
    return (rm == RM_DYN) ? frm : rm;
  endfunction

  // Encodings above RMM are reserved once the dynamic mode has been resolved.
  function automatic logic rm_is_reserved(input logic [2:0] rm);
    return rm > RM_RMM;
  endfunction

endpackage

// File: rtl/fpu_classify_sp.sv
// Purely combinational binary32 decoder: splits fields, restores the hidden
// bit and produces mutually exclusive class flags (sNaN implies NaN).
module fpu_classify_sp
  import fpu_cvt_unpack_pkg::*;
(
  input  logic [31:0] op,
  output logic        sign,
  output logic [7:0]  exp,
  output logic [23:0] sig,
  output fp_class_t   cls,
  output logic        is_exp_neg
);

  fp32_t f;
  logic  frac_nz;
  logic  exp_max;

  assign f       = op;
  assign frac_nz = |f.frac;
  assign exp_max = (f.exp == EXP_ALL_ONES);

  assign sign = f.sign;
  assign exp  = f.exp;
  assign sig  = {f.exp != 8'd0, f.frac};

  always_comb begin
    // NOTE: every output of this block gets a default first so no path
    // through the branches leaves it unassigned, which would infer a latch.
    cls = '0;
    if (exp_max) begin
      cls.is_nan  = frac_nz;
      cls.is_snan = frac_nz & ~f.frac[22];
      cls.is_inf  = ~frac_nz;
    end else if (f.exp == 8'd0) begin
      cls.is_zero = ~frac_nz;
      cls.is_sub  = frac_nz;
    end
  end

  // Zero and subnormals fall out naturally since their exponent field is 0.
  assign is_exp_neg = (f.exp < EXP_BIAS) & ~exp_max;

endmodule

// File: rtl/fpu_cvt_unpack.sv
// Two-stage unpack front end for FCVT.W[U].S: S1 captures the raw operand and
// resolved rounding mode, S2 captures the decoded fields for the converter.
module fpu_cvt_unpack
  import fpu_cvt_unpack_pkg::*;
#(
  parameter int TAG_W = 5
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [31:0]      op_a_i,
  input  logic [2:0]       rm_i,
  input  logic [2:0]       frm_i,
  input  logic             is_unsigned_i,
  input  logic [TAG_W-1:0] tag_i,
  output logic             out_valid_o,
  input  logic             out_ready_i,
  output logic             sign_o,
  output logic [7:0]       exp_o,
  output logic [23:0]      sig_o,
  output logic             is_nan_o,
  output logic             is_snan_o,
  output logic             is_inf_o,
  output logic             is_zero_o,
  output logic             is_sub_o,
  output logic             is_exp_neg_o,
  output logic [2:0]       rm_o,
  output logic             illegal_rm_o,
  output logic             is_unsigned_o,
  output logic [TAG_W-1:0] tag_o
);

  logic             s1_valid;
  logic [31:0]      s1_op;
  logic [2:0]       s1_rm;
  logic             s1_unsigned;
  logic [TAG_W-1:0] s1_tag;

  logic s2_advance;
  logic s1_advance;
  logic accept;
  logic s2_load;

  logic        dec_sign;
  logic [7:0]  dec_exp;
  logic [23:0] dec_sig;
  fp_class_t   dec_cls;
  logic        dec_exp_neg;

  // S2 frees up when empty or drained this cycle; S1 rides on that.
  assign s2_advance = ~out_valid_o | out_ready_i;
  assign s1_advance = ~s1_valid | s2_advance;
  assign in_ready_o = reset_i & ~flush_i & s1_advance;
  assign accept     = in_valid_i & in_ready_o;
  assign s2_load    = s2_advance & s1_valid;

  always_ff @(posedge clk_i or negedge reset_i) begin
    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, independent of order.
    if (!reset_i) begin
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
    end else if (flush_i) begin
      s1_valid    <= 1'b0;
      out_valid_o <= 1'b0;
    end else begin
      if (s1_advance) s1_valid    <= accept;
      if (s2_advance) out_valid_o <= s1_valid;
    end
  end

  // NOTE: S1 payload has no reset; its contents are only ever observed
  // through s1_valid, so a reset would add routing without changing behaviour.
  always_ff @(posedge clk_i) begin
    if (accept) begin
      s1_op       <= op_a_i;
      s1_rm       <= resolve_rm(rm_i, frm_i);
      s1_unsigned <= is_unsigned_i;
      s1_tag      <= tag_i;
    end
  end

  fpu_classify_sp u_classify (
    .op         (s1_op),
    .sign       (dec_sign),
    .exp        (dec_exp),
    .sig        (dec_sig),
    .cls        (dec_cls),
    .is_exp_neg (dec_exp_neg)
  );

  // S2 payload drives module outputs directly, so it is cleared by reset to
  // present all-zero fields while the block is held in reset.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      sign_o        <= 1'b0;
      exp_o         <= '0;
      sig_o         <= '0;
      is_nan_o      <= 1'b0;
      is_snan_o     <= 1'b0;
      is_inf_o      <= 1'b0;
      is_zero_o     <= 1'b0;
      is_sub_o      <= 1'b0;
      is_exp_neg_o  <= 1'b0;
      rm_o          <= '0;
      illegal_rm_o  <= 1'b0;
      is_unsigned_o <= 1'b0;
      tag_o         <= '0;
    end else if (s2_load) begin
      sign_o        <= dec_sign;
      exp_o         <= dec_exp;
      sig_o         <= dec_sig;
      is_nan_o      <= dec_cls.is_nan;
      is_snan_o     <= dec_cls.is_snan;
      is_inf_o      <= dec_cls.is_inf;
      is_zero_o     <= dec_cls.is_zero;
      is_sub_o      <= dec_cls.is_sub;
      is_exp_neg_o  <= dec_exp_neg;
      rm_o          <= s1_rm;
      illegal_rm_o  <= rm_is_reserved(s1_rm);
      is_unsigned_o <= s1_unsigned;
      tag_o         <= s1_tag;
    end
  end

endmodule

// File: tb/tb_fpu_cvt_unpack.sv
// Scoreboard bench for fpu_cvt_unpack: expectations queued on acceptance,
// compared in order as the consumer takes each output.
module tb_fpu_cvt_unpack;

  typedef struct packed {
    logic        sign;
    logic [7:0]  exp;
    logic [23:0] sig;
    logic [4:0]  cls;      // {nan, snan, inf, zero, sub}
    logic        exp_neg;
    logic [2:0]  rm;
    logic        illegal;
    logic        uns;
    logic [4:0]  tag;
  } out_t;

  logic        clk = 1'b0;
  logic        reset_i = 1'b0;
  logic        flush_i = 1'b0;
  logic        in_valid_i = 1'b0;
  logic        in_ready_o;
  logic [31:0] op_a_i = '0;
  logic [2:0]  rm_i = '0;
  logic [2:0]  frm_i = '0;
  logic        is_unsigned_i = 1'b0;
  logic [4:0]  tag_i = '0;
  logic        out_valid_o;
  logic        out_ready_i = 1'b1;
  logic        sign_o;
  logic [7:0]  exp_o;
  logic [23:0] sig_o;
  logic        is_nan_o, is_snan_o, is_inf_o, is_zero_o, is_sub_o;
  logic        is_exp_neg_o;
  logic [2:0]  rm_o;
  logic        illegal_rm_o;
  logic        is_unsigned_o;
  logic [4:0]  tag_o;

  int n_tests = 0;
  int n_fail  = 0;
  int n_push  = 0;
  int n_drop  = 0;
  int n_out   = 0;
  out_t sb[$];

  always #5 clk = ~clk;

  fpu_cvt_unpack #(.TAG_W(5)) dut (
    .clk_i         (clk),
    .reset_i       (reset_i),
    .flush_i       (flush_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .op_a_i        (op_a_i),
    .rm_i          (rm_i),
    .frm_i         (frm_i),
    .is_unsigned_i (is_unsigned_i),
    .tag_i         (tag_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .sign_o        (sign_o),
    .exp_o         (exp_o),
    .sig_o         (sig_o),
    .is_nan_o      (is_nan_o),
    .is_snan_o     (is_snan_o),
    .is_inf_o      (is_inf_o),
    .is_zero_o     (is_zero_o),
    .is_sub_o      (is_sub_o),
    .is_exp_neg_o  (is_exp_neg_o),
    .rm_o          (rm_o),
    .illegal_rm_o  (illegal_rm_o),
    .is_unsigned_o (is_unsigned_o),
    .tag_o         (tag_o)
  );

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic out_t get_out();
    out_t o;
    o.sign    = sign_o;
    o.exp     = exp_o;
    o.sig     = sig_o;
    o.cls     = {is_nan_o, is_snan_o, is_inf_o, is_zero_o, is_sub_o};
    o.exp_neg = is_exp_neg_o;
    o.rm      = rm_o;
    o.illegal = illegal_rm_o;
    o.uns     = is_unsigned_o;
    o.tag     = tag_o;
    return o;
  endfunction

  function automatic out_t mk(input logic s, input logic [7:0] e, input logic [23:0] sg,
                              input logic [4:0] c, input logic en, input logic [2:0] r,
                              input logic il, input logic u, input logic [4:0] t);
    out_t o;
    o.sign = s; o.exp = e; o.sig = sg; o.cls = c; o.exp_neg = en;
    o.rm = r; o.illegal = il; o.uns = u; o.tag = t;
    return o;
  endfunction

  // Reference decode for random traffic.
  function automatic out_t model(input logic [31:0] op, input logic [2:0] rm,
                                 input logic [2:0] frm, input logic u, input logic [4:0] t);
    logic [7:0]  e;
    logic [22:0] fr;
    logic [2:0]  r;
    logic [4:0]  c;
    e  = op[30:23];
    fr = op[22:0];
    r  = (rm == 3'b111) ? frm : rm;
    c  = 5'b00000;
    if (e == 8'hFF && fr != 0) c = fr[22] ? 5'b10000 : 5'b11000;
    else if (e == 8'hFF)       c = 5'b00100;
    else if (e == 8'h00 && fr == 0) c = 5'b00010;
    else if (e == 8'h00)       c = 5'b00001;
    return mk(op[31], e, {(e != 8'h00), fr}, c, (e != 8'hFF) && (e < 8'd127),
              r, (r == 3'b101) || (r == 3'b110) || (r == 3'b111), u, t);
  endfunction

  // Called just after a rising edge; returns just after the acceptance edge.
  task automatic send(input logic [31:0] op, input logic [2:0] rm, input logic [2:0] frm,
                      input logic u, input logic [4:0] t, input out_t e);
    int waited;
    waited = 0;
    in_valid_i = 1'b1; op_a_i = op; rm_i = rm; frm_i = frm; is_unsigned_i = u; tag_i = t;
    forever begin
      @(negedge clk);
      if (in_ready_o) begin
        sb.push_back(e);
        n_push++;
        break;
      end
      waited++;
      if (waited > 50) begin
        check("send_timeout", in_ready_o, 1'b1);
        break;
      end
    end
    @(posedge clk); #1;
    in_valid_i = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((sb.size() != 0 || out_valid_o) && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    check("drain", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (out_valid_o && out_ready_i) begin
      if (sb.size() == 0) begin
        check("spurious", out_valid_o, 1'b0);
      end else begin
        check($sformatf("out%0d", n_out), get_out(), sb.pop_front());
        n_out++;
      end
    end
  end

  out_t e_a, e_b, e_c, e_pi;

  initial begin
    e_pi = mk(0, 8'h80, 24'hC90FDB, 5'b00000, 0, 3'b000, 0, 0, 5'd9);

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("rst_in_ready", in_ready_o, 1'b0);
    check("rst_out_valid", out_valid_o, 1'b0);
    check("rst_payload", get_out(), '0);
    reset_i = 1'b1;
    @(posedge clk); #1;
    check("post_rst_ready", in_ready_o, 1'b1);

    // 1.0 with two-cycle latency.
    send(32'h3F800000, 3'b000, 3'b000, 0, 5'd1,
         mk(0, 8'h7F, 24'h800000, 5'b00000, 0, 3'b000, 0, 0, 5'd1));
    check("lat1_a", out_valid_o, 1'b0);
    @(posedge clk); #1;
    check("lat1_b", out_valid_o, 1'b1);
    wait_drain();

    // Back-to-back: 0.5 then the smallest subnormal.
    send(32'h3F000000, 3'b001, 3'b000, 1, 5'd2,
         mk(0, 8'h7E, 24'h800000, 5'b00000, 1, 3'b001, 0, 1, 5'd2));
    send(32'h00000001, 3'b010, 3'b000, 0, 5'd3,
         mk(0, 8'h00, 24'h000001, 5'b00001, 1, 3'b010, 0, 0, 5'd3));
    // NaN / Inf / zero classes.
    send(32'h7F800001, 3'b000, 3'b000, 0, 5'd4,
         mk(0, 8'hFF, 24'h800001, 5'b11000, 0, 3'b000, 0, 0, 5'd4));
    send(32'h7FC00000, 3'b000, 3'b000, 0, 5'd5,
         mk(0, 8'hFF, 24'hC00000, 5'b10000, 0, 3'b000, 0, 0, 5'd5));
    send(32'hFF800000, 3'b000, 3'b000, 0, 5'd6,
         mk(1, 8'hFF, 24'h800000, 5'b00100, 0, 3'b000, 0, 0, 5'd6));
    send(32'h80000000, 3'b100, 3'b000, 0, 5'd7,
         mk(1, 8'h00, 24'h000000, 5'b00010, 1, 3'b100, 0, 0, 5'd7));
    // Rounding-mode resolution.
    send(32'h3F800000, 3'b111, 3'b011, 0, 5'd8,
         mk(0, 8'h7F, 24'h800000, 5'b00000, 0, 3'b011, 0, 0, 5'd8));
    send(32'h3F800000, 3'b101, 3'b000, 0, 5'd9,
         mk(0, 8'h7F, 24'h800000, 5'b00000, 0, 3'b101, 1, 0, 5'd9));
    send(32'h3F800000, 3'b111, 3'b110, 1, 5'd10,
         mk(0, 8'h7F, 24'h800000, 5'b00000, 0, 3'b110, 1, 1, 5'd10));
    wait_drain();

    // Backpressure: two accepts fill the pipe, outputs hold, then drain.
    e_a = mk(0, 8'h80, 24'h800000, 5'b00000, 0, 3'b000, 0, 0, 5'd11);
    e_b = mk(1, 8'h81, 24'hC00000, 5'b00000, 0, 3'b001, 0, 1, 5'd12);
    e_c = mk(0, 8'h7D, 24'hA00000, 5'b00000, 1, 3'b010, 0, 0, 5'd13);
    out_ready_i = 1'b0;
    fork
      begin
        send(32'h40000000, 3'b000, 3'b000, 0, 5'd11, e_a);
        send(32'hC0C00000, 3'b001, 3'b000, 1, 5'd12, e_b);
        send(32'h3EA00000, 3'b010, 3'b000, 0, 5'd13, e_c);
      end
      begin
        repeat (4) @(negedge clk);
        check("stall_ready", in_ready_o, 1'b0);
        for (int i = 0; i < 3; i++) begin
          check($sformatf("stall_valid%0d", i), out_valid_o, 1'b1);
          check($sformatf("stall_hold%0d", i), get_out(), e_a);
          @(negedge clk);
        end
        @(posedge clk); #1;
        out_ready_i = 1'b1;
      end
    join
    wait_drain();

    // Flush with two in flight and a simultaneous offer.
    out_ready_i = 1'b0;
    send(32'h3F800000, 3'b000, 3'b000, 0, 5'd20, e_a);
    send(32'h3F800000, 3'b000, 3'b000, 0, 5'd21, e_a);
    flush_i = 1'b1;
    in_valid_i = 1'b1;
    op_a_i = 32'h12345678;
    #1;
    check("flush_ready", in_ready_o, 1'b0);
    @(posedge clk); #1;
    flush_i = 1'b0;
    in_valid_i = 1'b0;
    n_drop += sb.size();
    sb.delete();
    check("flush_valid", out_valid_o, 1'b0);
    out_ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("flush_idle", out_valid_o, 1'b0);
    send(32'h40490FDB, 3'b000, 3'b000, 0, 5'd9, e_pi);
    check("lat2_a", out_valid_o, 1'b0);
    @(posedge clk); #1;
    check("lat2_b", out_valid_o, 1'b1);
    wait_drain();

    // Reset pulse with two in flight.
    out_ready_i = 1'b0;
    send(32'h3F800000, 3'b000, 3'b000, 0, 5'd22, e_a);
    send(32'h3F800000, 3'b000, 3'b000, 0, 5'd23, e_a);
    reset_i = 1'b0;
    #1;
    check("mrst_valid", out_valid_o, 1'b0);
    check("mrst_ready", in_ready_o, 1'b0);
    check("mrst_payload", get_out(), '0);
    @(posedge clk); #1;
    reset_i = 1'b1;
    n_drop += sb.size();
    sb.delete();
    out_ready_i = 1'b1;
    @(posedge clk); #1;
    check("mrst_ready_after", in_ready_o, 1'b1);
    check("mrst_idle", out_valid_o, 1'b0);
    send(32'h40490FDB, 3'b000, 3'b000, 0, 5'd9, e_pi);
    check("lat3_a", out_valid_o, 1'b0);
    @(posedge clk); #1;
    check("lat3_b", out_valid_o, 1'b1);
    wait_drain();

    // Random traffic under random backpressure.
    fork
      begin
        for (int i = 0; i < 40; i++) begin
          logic [31:0] op;
          logic [2:0]  rm, frm;
          logic        u;
          logic [4:0]  t;
          op = $urandom;
          case ($urandom_range(0, 4))
            0: ;
            1: op[30:23] = 8'h00;
            2: op[30:23] = 8'hFF;
            3: op[30:23] = 8'h7E + 8'($urandom_range(0, 2));
            default: op[30:0] = '0;
          endcase
          rm = 3'($urandom); frm = 3'($urandom); u = 1'($urandom); t = 5'($urandom);
          send(op, rm, frm, u, t, model(op, rm, frm, u, t));
        end
      end
      begin
        repeat (80) begin
          @(posedge clk); #1;
          out_ready_i = 1'($urandom);
        end
        out_ready_i = 1'b1;
      end
    join
    wait_drain();
    check("count", n_out, n_push - n_drop);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
